// File: rtl/cmp_arbiter.sv
// Two-requester arbiter in front of a single RV32I branch comparator: IDLE -> EXEC -> RESP.
// Optional macro CMP_ARB_ROUND_ROBIN_EN selects round-robin grant; undefined gives fixed priority to requester 0.
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_funct3,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_funct3,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_taken,
    output logic             rsp_eq,
    output logic             rsp_lu,
    output logic             rsp_ls,
    output logic             rsp_illegal,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] req_a      [2];
    logic [WIDTH-1:0] req_b      [2];
    logic [2:0]       req_funct3 [2];
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;

    assign req_valid     = {req1_valid, req0_valid};
    assign req_a[0]      = req0_a;
    assign req_a[1]      = req1_a;
    assign req_b[0]      = req0_b;
    assign req_b[1]      = req1_b;
    assign req_funct3[0] = req0_funct3;
    assign req_funct3[1] = req1_funct3;

    logic grant_any;
    logic grant_id;
    logic tie_winner;
    logic accept;

    assign grant_any = |req_valid;
    // Requester 1 wins when it is alone, or when both are valid and the tie goes its way.
    assign grant_id  = req_valid[1] & (~req_valid[0] | tie_winner);
    assign accept    = (state_reg == IDLE) & grant_any & ~reset;

`ifdef CMP_ARB_ROUND_ROBIN_EN
    logic rr_ptr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= 1'b0;
        end else if (accept) begin
            rr_ptr_reg <= ~grant_id;
        end
    end

    assign tie_winner = rr_ptr_reg;
`else
    assign tie_winner = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept & (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // Operand capture happens only on the grant edge.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       funct3_reg;
    logic             id_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            funct3_reg <= 3'b000;
            id_reg     <= 1'b0;
        end else if (accept) begin
            a_reg      <= req_a[grant_id];
            b_reg      <= req_b[grant_id];
            funct3_reg <= req_funct3[grant_id];
            id_reg     <= grant_id;
        end
    end

    logic [WIDTH:0] diff;
    logic           flag_eq;
    logic           flag_lu;
    logic           flag_ls;
    logic           a_sign;
    logic           b_sign;

    assign diff    = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, 1'b1};
    assign a_sign  = a_reg[WIDTH-1];
    assign b_sign  = b_reg[WIDTH-1];
    assign flag_eq = (diff[WIDTH-1:0] == '0);
    assign flag_lu = ~diff[WIDTH];
    assign flag_ls = (a_sign & ~b_sign) | (~(a_sign ^ b_sign) & diff[WIDTH-1]);

    logic cond_taken;
    logic cond_illegal;

    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        case (funct3_reg)
            3'b000:  cond_taken = flag_eq;
            3'b001:  cond_taken = ~flag_eq;
            3'b100:  cond_taken = flag_ls;
            3'b101:  cond_taken = ~flag_ls;
            3'b110:  cond_taken = flag_lu;
            3'b111:  cond_taken = ~flag_lu;
            default: cond_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id      <= 1'b0;
            rsp_taken   <= 1'b0;
            rsp_eq      <= 1'b0;
            rsp_lu      <= 1'b0;
            rsp_ls      <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_id      <= id_reg;
            rsp_taken   <= cond_taken;
            rsp_eq      <= flag_eq;
            rsp_lu      <= flag_lu;
            rsp_ls      <= flag_ls;
            rsp_illegal <= cond_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rsp_valid = (state_reg == RESP);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomised self-checking bench for cmp_arbiter against a behavioural compare/arbitration model.
module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_funct3, req1_funct3;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_taken;
    logic        rsp_eq, rsp_lu, rsp_ls, rsp_illegal, busy;

    int n_cmp = 0;
    int n_err = 0;
    bit mdl_fav1 = 1'b0;

    cmp_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_funct3(req0_funct3),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_funct3(req1_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_taken(rsp_taken), .rsp_eq(rsp_eq), .rsp_lu(rsp_lu),
        .rsp_ls(rsp_ls), .rsp_illegal(rsp_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string ph, input bit id, input bit tk, input bit eq,
                             input bit lu, input bit ls, input bit il);
        check({ph, "_valid"}, rsp_valid, 1);
        check({ph, "_id"}, rsp_id, id);
        check({ph, "_taken"}, rsp_taken, tk);
        check({ph, "_eq"}, rsp_eq, eq);
        check({ph, "_lu"}, rsp_lu, lu);
        check({ph, "_ls"}, rsp_ls, ls);
        check({ph, "_illegal"}, rsp_illegal, il);
        check({ph, "_ready0"}, req0_ready, 0);
        check({ph, "_ready1"}, req1_ready, 0);
    endtask

    // One complete request/response; called #1 after a rising edge with the DUT in IDLE.
    task automatic txn(input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] f0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] f1,
                       input int hold);
        int g;
        logic [31:0] ea, eb;
        logic [2:0] ef;
        bit e_eq, e_lu, e_ls, e_tk, e_il;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_funct3 = f0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_funct3 = f1;
        rsp_ready = 1'b0;
        #1;
        g = (v1 && (!v0 || mdl_fav1)) ? 1 : 0;
        check("grant_ready0", req0_ready, (v0 && g == 0) ? 1 : 0);
        check("grant_ready1", req1_ready, (v1 && g == 1) ? 1 : 0);
        check("idle_busy", busy, 0);
`ifdef CMP_ARB_ROUND_ROBIN_EN
        mdl_fav1 = (g == 0);
`endif
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        ef = (g == 1) ? f1 : f0;
        e_eq = (ea == eb);
        e_lu = (ea < eb);
        e_ls = ($signed(ea) < $signed(eb));
        e_il = (ef == 3'b010 || ef == 3'b011);
        case (ef)
            3'b000: e_tk = e_eq;
            3'b001: e_tk = !e_eq;
            3'b100: e_tk = e_ls;
            3'b101: e_tk = !e_ls;
            3'b110: e_tk = e_lu;
            3'b111: e_tk = !e_lu;
            default: e_tk = 1'b0;
        endcase
        @(posedge clk); #1;
        // Operands changing after the grant must not disturb the pending result.
        req0_a = $urandom; req0_b = $urandom; req0_funct3 = 3'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_funct3 = 3'($urandom);
        check("exec_ready0", req0_ready, 0);
        check("exec_ready1", req1_ready, 0);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_busy", busy, 1);
        @(posedge clk); #1;
        check_rsp("rsp", 1'(g), e_tk, e_eq, e_lu, e_ls, e_il);
        check("rsp_busy", busy, 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_rsp("hold", 1'(g), e_tk, e_eq, e_lu, e_ls, e_il);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
        $display("txn v=%0b%0b id=%0d a=%08h b=%08h f3=%03b taken=%0b eq=%0b lu=%0b ls=%0b ill=%0b hold=%0d",
                 v1, v0, g, ea, eb, ef, e_tk, e_eq, e_lu, e_ls, e_il, hold);
    endtask

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 0; req0_b = 0; req0_funct3 = 0;
        req1_a = 0; req1_b = 0; req1_funct3 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {rsp_id, rsp_taken, rsp_eq, rsp_lu, rsp_ls, rsp_illegal}, 0);
        reset = 1'b0;
        mdl_fav1 = 1'b0;

        // Continuous contention, one response held back for 4 cycles.
        txn(1, 1, 32'd10, 32'd20, 3'b100, 32'd30, 32'd30, 3'b000, 0);
        txn(1, 1, 32'd10, 32'd20, 3'b100, 32'd30, 32'd30, 3'b000, 4);
        txn(1, 1, 32'd10, 32'd20, 3'b100, 32'd30, 32'd30, 3'b000, 0);
        txn(1, 1, 32'd10, 32'd20, 3'b100, 32'd30, 32'd30, 3'b000, 0);

        // Directed single-requester cases.
        txn(1, 0, 32'd5, 32'd5, 3'b000, 0, 0, 3'b000, 0);
        txn(0, 1, 0, 0, 3'b000, 32'hFFFF_FFFF, 32'd1, 3'b100, 0);
        txn(1, 0, 32'd1, 32'hFFFF_FFFF, 3'b110, 0, 0, 3'b000, 1);
        txn(1, 0, 32'd3, 32'd7, 3'b010, 0, 0, 3'b000, 0);

        for (int i = 0; i < 40; i++) begin
            int vp;
            logic [31:0] a0, b0, a1, b1;
            vp = $urandom_range(1, 3);
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : 32'(a1 ^ 32'h8000_0000);
            txn(vp[0], vp[1], a0, b0, 3'($urandom), a1, b1, 3'($urandom), $urandom_range(0, 2));
        end

        // Reset while EXEC: abandon the compare, no response.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_funct3 = 3'b000;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_exec_busy", busy, 1);
        reset = 1'b1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        mdl_fav1 = 1'b0;
        @(posedge clk); #1;
        check("abort_no_rsp", rsp_valid, 0);
        check("abort_idle", busy, 0);
        txn(1, 0, 32'd2, 32'd9, 3'b101, 0, 0, 3'b000, 0);
        txn(1, 1, 32'd4, 32'd4, 3'b001, 32'd4, 32'd4, 3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
